// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the memory subsystem.
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM stage: issues loads/stores on a req/ack bus, stalls the pipe on wait
// states, extracts load data and holds the MEM/WB pipeline register.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] pcplusM,
    mem_access_if.master bus,
    output logic        stallM,
    output logic [31:0] instrW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic [31:0] pcplusW,
    output logic        addr_errW
);
    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t      state, state_nx;
    logic [31:0] l_instr, l_alu, l_wd, l_pc;
    logic [31:0] cur_instr, cur_alu, cur_wd, cur_pc;
    logic        is_load, is_store, is_mem, sgn, misal;
    size_t       sz;
    logic [31:0] rd_sh, rd_ext;

    // In WAIT the upstream registers are frozen, but the bus is driven from
    // the latched copy so it stays stable regardless of what arrives.
    always_comb begin
        if (state == WAIT) begin
            cur_instr = l_instr;
            cur_alu   = l_alu;
            cur_wd    = l_wd;
            cur_pc    = l_pc;
        end else begin
            cur_instr = instrM;
            cur_alu   = ALUOutM;
            cur_wd    = WriteDataM;
            cur_pc    = pcplusM;
        end
    end

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sgn      = 1'b0;
        sz       = SZ_W;
        unique case (cur_instr[31:26])
            6'h20: begin is_load  = 1'b1; sgn = 1'b1; sz = SZ_B; end
            6'h21: begin is_load  = 1'b1; sgn = 1'b1; sz = SZ_H; end
            6'h23: begin is_load  = 1'b1; sz = SZ_W; end
            6'h24: begin is_load  = 1'b1; sz = SZ_B; end
            6'h25: begin is_load  = 1'b1; sz = SZ_H; end
            6'h28: begin is_store = 1'b1; sz = SZ_B; end
            6'h29: begin is_store = 1'b1; sz = SZ_H; end
            6'h2B: begin is_store = 1'b1; sz = SZ_W; end
            default: ;
        endcase
        is_mem = is_load | is_store;
        misal  = ((sz == SZ_H) && cur_alu[0]) ||
                 ((sz == SZ_W) && (cur_alu[1:0] != 2'b00));
    end

    // Control: stallM sees only state, decode, alignment and mem_ack.
    always_comb begin
        state_nx    = state;
        bus.mem_req = 1'b0;
        stallM      = 1'b0;
        if (!rst && is_mem && !misal) bus.mem_req = 1'b1;
        stallM = bus.mem_req && !bus.mem_ack;
        unique case (state)
            IDLE: if (stallM)      state_nx = WAIT;
            WAIT: if (bus.mem_ack) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_be    = 4'h0;
        bus.mem_wdata = 32'h0;
        if (bus.mem_req) begin
            bus.mem_we   = is_store;
            bus.mem_addr = {cur_alu[31:2], 2'b00};
            bus.mem_be   = 4'hF;
            if (is_store) begin
                unique case (sz)
                    SZ_B: begin
                        bus.mem_be    = 4'b0001 << cur_alu[1:0];
                        bus.mem_wdata = {4{cur_wd[7:0]}};
                    end
                    SZ_H: begin
                        bus.mem_be    = cur_alu[1] ? 4'b1100 : 4'b0011;
                        bus.mem_wdata = {2{cur_wd[15:0]}};
                    end
                    default: bus.mem_wdata = cur_wd;
                endcase
            end
        end
    end

    // Alignment guarantees a halfword sits at offset 0 or 2, so one byte
    // shift serves every access size.
    always_comb begin
        rd_sh = bus.mem_rdata >> {cur_alu[1:0], 3'b000};
        unique case (sz)
            SZ_B:    rd_ext = {{24{sgn & rd_sh[7]}},  rd_sh[7:0]};
            SZ_H:    rd_ext = {{16{sgn & rd_sh[15]}}, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_instr <= 32'h0;
            l_alu   <= 32'h0;
            l_wd    <= 32'h0;
            l_pc    <= 32'h0;
        end else if (state == IDLE && stallM) begin
            l_instr <= instrM;
            l_alu   <= ALUOutM;
            l_wd    <= WriteDataM;
            l_pc    <= pcplusM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrW    <= 32'h0;
            ALUOutW   <= 32'h0;
            ReadDataW <= 32'h0;
            pcplusW   <= 32'h0;
            addr_errW <= 1'b0;
        end else if (stallM) begin
            instrW    <= 32'h0;
            ALUOutW   <= 32'h0;
            ReadDataW <= 32'h0;
            pcplusW   <= 32'h0;
            addr_errW <= 1'b0;
        end else if (is_mem && misal) begin
            instrW    <= 32'h0;
            ALUOutW   <= cur_alu;
            ReadDataW <= 32'h0;
            pcplusW   <= cur_pc;
            addr_errW <= 1'b1;
        end else begin
            instrW    <= cur_instr;
            ALUOutW   <= cur_alu;
            ReadDataW <= (bus.mem_req && is_load) ? rd_ext : 32'h0;
            pcplusW   <= cur_pc;
            addr_errW <= 1'b0;
        end
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- instrM  in  32  MEM-stage instruction from EX/MEM register
- ALUOutM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rt)
- pcplusM  in  32  PC+4 of MEM-stage instruction
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte enables, lane n = bits 8n+7:8n (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid when mem_ack = 1
- mem_ack  in  1  request completes this cycle
- stallM  out  1  freeze IF/ID/EX/MEM registers this cycle
- instrW, ALUOutW, ReadDataW, pcplusW  out  32 each  MEM/WB register outputs
- addr_errW  out  1  misaligned-access flag, registered with WB outputs

Function
REQ-002 Decode on instrM[31:26]: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; all other opcodes are non-memory.
REQ-003 Alignment: LH/LHU/SH SHALL require ALUOutM[0] = 0; LW/SW SHALL require ALUOutM[1:0] = 0; byte ops are always aligned.
REQ-004 FSM states: IDLE and WAIT.
REQ-005 IDLE with an aligned memory op: mem_req = 1 combinationally. mem_addr = {ALUOutM[31:2],2'b00}. mem_we = 1 for stores only.
REQ-006 IDLE, mem_ack = 1 in the same cycle: the op completes in that cycle, stallM = 0, and the state stays IDLE.
REQ-007 IDLE, mem_ack = 0: stallM = 1. The block latches instrM, ALUOutM, WriteDataM and pcplusM, then moves to WAIT at the next edge.
REQ-008 WAIT: mem_req = 1, with addr/we/be/wdata driven from the latched copy and held stable every cycle until mem_ack.
- stallM = !mem_ack.
- On mem_ack the op completes and the state returns to IDLE at that edge.
REQ-009 Store lanes:
- SB: be = 1 << addr[1:0], wdata = {4{WriteData[7:0]}}.
- SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{WriteData[15:0]}}.
- SW: be = 4'b1111, wdata = WriteData.
- Loads: be = 4'b1111.
REQ-010 Load extraction from mem_rdata by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-011 MEM/WB register, on every rising edge:
- Completing op, or non-memory instruction in IDLE: load instr, ALUOut and pcplus. ReadDataW = extracted load data for loads, 0 otherwise. addr_errW = 0.
- Stall cycle (stallM = 1): load a bubble, with all four 32-bit outputs = 0 and addr_errW = 0.
REQ-012 Misaligned memory op in IDLE: mem_req = 0 and stallM = 0.
- WB loads instrW = 0, ALUOutW = offending address, ReadDataW = 0, pcplusW = pcplusM, addr_errW = 1.
- addr_errW is a 1-cycle pulse per offending instruction.
REQ-013 mem_ack SHALL be ignored whenever mem_req = 0.
REQ-014 When mem_req = 0: mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
REQ-015 Latency:
- Zero-wait memory: 1 cycle, no stall.
- N wait cycles: stallM is high for exactly N cycles.
REQ-016 stallM SHALL depend combinationally only on state, instrM decode, alignment and mem_ack. It SHALL have no path from mem_rdata.

Reset
REQ-017 rst = 1 SHALL immediately force:
- state = IDLE;
- instrW, ALUOutW, ReadDataW, pcplusW = 0 and addr_errW = 0;
- latched copies = 0.
REQ-018 Reset asserted in WAIT SHALL deassert mem_req asynchronously and abandon the access. After release, the block SHALL not reissue the access until the instruction is presented again.
REQ-019 While rst = 1, the outputs mem_req and stallM SHALL be 0.

Verification
REQ-020 Zero-wait LW: instrM = 0x8C080004, ALUOutM = 0x100, mem_ack = 1 same cycle, mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, be = 0xF, stallM = 0; next edge: ReadDataW = 0xDEADBEEF, instrW = 0x8C080004.
REQ-021 LB sign/zero extension: ALUOutM = 0x103, mem_rdata = 0x80123456 -> LB gives ReadDataW = 0xFFFFFF80; LBU gives ReadDataW = 0x00000080.
REQ-022 SH with 2 wait cycles: ALUOutM = 0x202, WriteDataM = 0x0000ABCD, mem_ack on the 3rd cycle.
- mem_req = 1 for 3 cycles with be = 0xC and wdata = 0xABCDABCD stable.
- stallM = 1,1,0.
- WB gets 2 bubbles, then the SH.
REQ-023 Misaligned LW at ALUOutM = 0x301 -> mem_req = 0, stallM = 0; next edge: addr_errW = 1, ALUOutW = 0x301, instrW = 0; the following cycle addr_errW = 0.
REQ-024 Reset mid-WAIT: assert rst while in WAIT with mem_ack = 0 -> mem_req = 0 and stallM = 0 before the next clock edge; after release, all W outputs = 0 and state = IDLE.
REQ-025 Non-memory stream: ADDU instructions back-to-back -> mem_req never asserted, stallM = 0, each appears on instrW one cycle later with ReadDataW = 0.
